// File: rtl/el2_ifu_ic_pkg.sv
// ---------------------------------------------------------------------------
// el2_ifu_ic_pkg
// Shared definitions for the IFU instruction-cache way memory:
//   - default geometry and the derived widths IDX_W (set index) and PAR_W
//     (one parity bit per 16-bit data chunk)
//   - even-parity generator used for fill writes and for lookup checking
//   - debug access sequencer state encoding
// ---------------------------------------------------------------------------
package el2_ifu_ic_pkg;

    localparam int WAYS_DEF   = 2;
    localparam int SETS_DEF   = 128;
    localparam int DATA_W_DEF = 64;
    localparam int TAG_W_DEF  = 21;

    function automatic int f_idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int f_par_w(input int data_w);
        return data_w / 16;
    endfunction

    localparam int IDX_W = f_idx_w(SETS_DEF);
    localparam int PAR_W = f_par_w(DATA_W_DEF);

    // Even parity: the returned bit makes the total count of ones even.
    // Callers zero-extend narrower operands, which leaves the parity unchanged.
    function automatic logic even_par(input logic [63:0] v);
        return ^v;
    endfunction

    typedef enum logic [1:0] {
        DBG_IDLE   = 2'd0,
        DBG_ACCESS = 2'd1,
        DBG_DONE   = 2'd2
    } dbg_state_e;

endpackage

// File: rtl/el2_ifu_ic_way_mem_if.sv
// ---------------------------------------------------------------------------
// el2_ifu_ic_way_mem_if
// Bundle of every lookup, fill and debug signal of the IC way memory.
//   master : the IFU side (drives requests, receives results)
//   slave  : the way memory
// Debug payload layout: data access = {parity[PW-1:0], data[DATA_W-1:0]},
// parity bit c covering data[16c+15:16c]; tag access = {parity, tag} in
// bits [TAG_W:0].
// ---------------------------------------------------------------------------
interface el2_ifu_ic_way_mem_if #(
    parameter int WAYS   = el2_ifu_ic_pkg::WAYS_DEF,
    parameter int SETS   = el2_ifu_ic_pkg::SETS_DEF,
    parameter int DATA_W = el2_ifu_ic_pkg::DATA_W_DEF,
    parameter int TAG_W  = el2_ifu_ic_pkg::TAG_W_DEF
);
    localparam int IW = el2_ifu_ic_pkg::f_idx_w(SETS);
    localparam int PW = el2_ifu_ic_pkg::f_par_w(DATA_W);

    // lookup
    logic                 io_rd_en;
    logic [IW-1:0]        io_rd_index;
    logic [TAG_W-1:0]     io_rd_tag;
    logic [WAYS-1:0]      io_tag_valid;
    // fill
    logic [WAYS-1:0]      io_wr_en;
    logic [IW-1:0]        io_wr_index;
    logic [TAG_W-1:0]     io_wr_tag;
    logic [DATA_W-1:0]    io_wr_data;
    logic                 io_ecc_disable;
    // debug
    logic                 io_debug_rd_en;
    logic                 io_debug_wr_en;
    logic                 io_debug_tag_array;
    logic [1:0]           io_debug_way;
    logic [IW-1:0]        io_debug_index;
    logic [DATA_W+PW-1:0] io_debug_wr_data;
    // results
    logic                 io_rd_valid;
    logic [WAYS-1:0]      io_rd_hit;
    logic [DATA_W-1:0]    io_rd_data;
    logic [WAYS-1:0]      io_parerr;
    logic                 io_tag_perr;
    logic                 io_multihit;
    logic                 io_debug_done;
    logic [DATA_W+PW-1:0] io_debug_rd_data;

    modport master (
        output io_rd_en, io_rd_index, io_rd_tag, io_tag_valid,
               io_wr_en, io_wr_index, io_wr_tag, io_wr_data, io_ecc_disable,
               io_debug_rd_en, io_debug_wr_en, io_debug_tag_array,
               io_debug_way, io_debug_index, io_debug_wr_data,
        input  io_rd_valid, io_rd_hit, io_rd_data, io_parerr, io_tag_perr,
               io_multihit, io_debug_done, io_debug_rd_data
    );

    modport slave (
        input  io_rd_en, io_rd_index, io_rd_tag, io_tag_valid,
               io_wr_en, io_wr_index, io_wr_tag, io_wr_data, io_ecc_disable,
               io_debug_rd_en, io_debug_wr_en, io_debug_tag_array,
               io_debug_way, io_debug_index, io_debug_wr_data,
        output io_rd_valid, io_rd_hit, io_rd_data, io_parerr, io_tag_perr,
               io_multihit, io_debug_done, io_debug_rd_data
    );
endinterface

// File: rtl/el2_ifu_ic_way_bank.sv
// ---------------------------------------------------------------------------
// el2_ifu_ic_way_bank
// Storage for one cache way: tag array {par, tag} and data array
// {par[PW-1:0], data}.
//   clock                  : clock
//   rd_en / rd_index       : registered lookup read (read-first vs. writes)
//   fill_*                 : fill write, parity generated here
//   dbg_wr_tag/dbg_wr_data : raw debug write of payload (parity verbatim)
//   dbg_index              : debug location, also drives the raw read port
//   rd_tag / rd_data       : registered lookup tag / data
//   rd_tag_perr/rd_data_perr : parity mismatch of the registered entries
//   dbg_tag_raw/dbg_data_raw : combinational raw read at dbg_index
// ---------------------------------------------------------------------------
module el2_ifu_ic_way_bank
    import el2_ifu_ic_pkg::*;
#(
    parameter  int SETS   = SETS_DEF,
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int TAG_W  = TAG_W_DEF,
    localparam int IW     = f_idx_w(SETS),
    localparam int PW     = f_par_w(DATA_W),
    localparam int DW_RAW = DATA_W + PW,
    localparam int TW_RAW = TAG_W + 1
) (
    input  logic              clock,
    input  logic              rd_en,
    input  logic [IW-1:0]     rd_index,
    input  logic              fill_en,
    input  logic [IW-1:0]     fill_index,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              dbg_wr_tag,
    input  logic              dbg_wr_data,
    input  logic [IW-1:0]     dbg_index,
    input  logic [DW_RAW-1:0] dbg_payload,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_tag_perr,
    output logic              rd_data_perr,
    output logic [TW_RAW-1:0] dbg_tag_raw,
    output logic [DW_RAW-1:0] dbg_data_raw
);
    logic [TW_RAW-1:0] tag_mem  [SETS];
    logic [DW_RAW-1:0] data_mem [SETS];
    logic [TW_RAW-1:0] tag_q;
    logic [DW_RAW-1:0] data_q;
    logic [PW-1:0]     fill_par;

    always_comb begin
        fill_par = '0;
        for (int c = 0; c < PW; c++) begin
            fill_par[c] = even_par(64'(fill_data[c*16 +: 16]));
        end
    end

    // NOTE: the arrays have no reset; clearing them would need a per-entry
    // walk and the valid bits held outside already mark unused lines.
    // The debug write comes after the fill so it wins on a same-location clash.
    always_ff @(posedge clock) begin
        if (fill_en) begin
            tag_mem[fill_index]  <= {even_par(64'(fill_tag)), fill_tag};
            data_mem[fill_index] <= {fill_par, fill_data};
        end
        if (dbg_wr_tag) begin
            tag_mem[dbg_index] <= dbg_payload[TW_RAW-1:0];
        end
        if (dbg_wr_data) begin
            data_mem[dbg_index] <= dbg_payload;
        end
    end

    // Reads sample the pre-edge contents, giving read-first behaviour.
    always_ff @(posedge clock) begin
        if (rd_en) begin
            tag_q  <= tag_mem[rd_index];
            data_q <= data_mem[rd_index];
        end
    end

    always_comb begin
        rd_data_perr = 1'b0;
        for (int c = 0; c < PW; c++) begin
            rd_data_perr = rd_data_perr |
                (even_par(64'(data_q[c*16 +: 16])) ^ data_q[DATA_W + c]);
        end
    end

    assign rd_tag       = tag_q[TAG_W-1:0];
    assign rd_data      = data_q[DATA_W-1:0];
    assign rd_tag_perr  = even_par(64'(tag_q));
    assign dbg_tag_raw  = tag_mem[dbg_index];
    assign dbg_data_raw = data_mem[dbg_index];

endmodule

// File: rtl/el2_ifu_ic_way_mem.sv
// ---------------------------------------------------------------------------
// el2_ifu_ic_way_mem
// N-way instruction-cache tag+data array with 1-cycle registered lookup,
// per-way hit, parity checking, hit-way data OR-mux and a sequenced debug
// read/write port (IDLE -> ACCESS -> DONE).
//   clock : clock
//   reset : synchronous, active-high
//   bus   : el2_ifu_ic_way_mem_if.slave (lookup, fill, debug, results)
// ---------------------------------------------------------------------------
module el2_ifu_ic_way_mem
    import el2_ifu_ic_pkg::*;
#(
    parameter int WAYS   = WAYS_DEF,
    parameter int SETS   = SETS_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
) (
    input logic                  clock,
    input logic                  reset,
    el2_ifu_ic_way_mem_if.slave  bus
);
    localparam int PW     = f_par_w(DATA_W);
    localparam int DW_RAW = DATA_W + PW;
    localparam int TW_RAW = TAG_W + 1;

    // lookup pipeline stage
    logic              valid_q;
    logic              ecc_dis_q;
    logic [WAYS-1:0]   tag_valid_q;
    logic [TAG_W-1:0]  lkp_tag_q;

    // per-way bank outputs
    logic [TAG_W-1:0]  way_tag      [WAYS];
    logic [DATA_W-1:0] way_data     [WAYS];
    logic [TW_RAW-1:0] dbg_tag_raw  [WAYS];
    logic [DW_RAW-1:0] dbg_data_raw [WAYS];
    logic [WAYS-1:0]   way_tag_perr;
    logic [WAYS-1:0]   way_data_perr;

    // debug sequencer
    dbg_state_e        state_q, state_d;
    logic              dbg_access;
    logic              dbg_done;
    logic [WAYS-1:0]   dbg_wr_sel;
    logic [DW_RAW-1:0] dbg_rd_sel;
    logic [DW_RAW-1:0] dbg_rd_data_q;

    // lookup results
    logic [WAYS-1:0]   hit;
    logic [DATA_W-1:0] hit_data;
    logic [WAYS-1:0]   parerr;
    logic              tag_perr;
    logic              multihit;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q     <= 1'b0;
            ecc_dis_q   <= 1'b0;
            tag_valid_q <= '0;
            lkp_tag_q   <= '0;
        end else begin
            valid_q   <= bus.io_rd_en;
            ecc_dis_q <= bus.io_ecc_disable;
            if (bus.io_rd_en) begin
                tag_valid_q <= bus.io_tag_valid;
                lkp_tag_q   <= bus.io_rd_tag;
            end
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        el2_ifu_ic_way_bank #(
            .SETS   (SETS),
            .DATA_W (DATA_W),
            .TAG_W  (TAG_W)
        ) u_bank (
            .clock        (clock),
            .rd_en        (bus.io_rd_en),
            .rd_index     (bus.io_rd_index),
            .fill_en      (bus.io_wr_en[w]),
            .fill_index   (bus.io_wr_index),
            .fill_tag     (bus.io_wr_tag),
            .fill_data    (bus.io_wr_data),
            .dbg_wr_tag   (dbg_wr_sel[w] & bus.io_debug_tag_array),
            .dbg_wr_data  (dbg_wr_sel[w] & ~bus.io_debug_tag_array),
            .dbg_index    (bus.io_debug_index),
            .dbg_payload  (bus.io_debug_wr_data),
            .rd_tag       (way_tag[w]),
            .rd_data      (way_data[w]),
            .rd_tag_perr  (way_tag_perr[w]),
            .rd_data_perr (way_data_perr[w]),
            .dbg_tag_raw  (dbg_tag_raw[w]),
            .dbg_data_raw (dbg_data_raw[w])
        );
    end

    // Hit detection and data OR-mux. Everything is qualified by valid_q so
    // the result outputs read zero whenever no lookup completes.
    always_comb begin
        hit      = '0;
        hit_data = '0;
        parerr   = '0;
        tag_perr = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            hit[w] = valid_q & tag_valid_q[w] & (way_tag[w] == lkp_tag_q);
            if (hit[w]) begin
                hit_data = hit_data | way_data[w];
            end
            parerr[w] = hit[w] & way_data_perr[w] & ~ecc_dis_q;
            tag_perr  = tag_perr |
                (valid_q & tag_valid_q[w] & way_tag_perr[w] & ~ecc_dis_q);
        end
        multihit = ($countones(hit) > 1) & ~ecc_dis_q;
    end

    // Debug sequencer: fetch traffic (lookup or fill) holds it in IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= DBG_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DBG_IDLE: begin
                if ((bus.io_debug_rd_en | bus.io_debug_wr_en) &
                    ~bus.io_rd_en & (bus.io_wr_en == '0)) begin
                    state_d = DBG_ACCESS;
                end
            end
            DBG_ACCESS: state_d = DBG_DONE;
            DBG_DONE:   state_d = DBG_IDLE;
            default:    state_d = DBG_IDLE;
        endcase
    end

    always_comb begin
        dbg_access = (state_q == DBG_ACCESS);
        dbg_done   = (state_q == DBG_DONE);
    end

    // Out-of-range ways match no bank: writes vanish and reads yield zero.
    always_comb begin
        dbg_wr_sel = '0;
        dbg_rd_sel = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (bus.io_debug_way == 2'(w)) begin
                dbg_wr_sel[w] = dbg_access & bus.io_debug_wr_en;
                dbg_rd_sel    = bus.io_debug_tag_array ? DW_RAW'(dbg_tag_raw[w])
                                                       : dbg_data_raw[w];
            end
        end
    end

    // A write takes precedence, so a combined request captures nothing.
    always_ff @(posedge clock) begin
        if (reset) begin
            dbg_rd_data_q <= '0;
        end else if (dbg_access & bus.io_debug_rd_en & ~bus.io_debug_wr_en) begin
            dbg_rd_data_q <= dbg_rd_sel;
        end
    end

    assign bus.io_rd_valid      = valid_q;
    assign bus.io_rd_hit        = hit;
    assign bus.io_rd_data       = hit_data;
    assign bus.io_parerr        = parerr;
    assign bus.io_tag_perr      = tag_perr;
    assign bus.io_multihit      = multihit;
    assign bus.io_debug_done    = dbg_done;
    assign bus.io_debug_rd_data = dbg_rd_data_q;

endmodule

// File: tb/tb_el2_ifu_ic_way_mem.sv
// ---------------------------------------------------------------------------
// tb_el2_ifu_ic_way_mem
// Directed bench for el2_ifu_ic_way_mem at the default geometry
// (2 ways, 128 sets, 64-bit data, 21-bit tag) with hand-computed results.
// ---------------------------------------------------------------------------
module tb_el2_ifu_ic_way_mem;
    import el2_ifu_ic_pkg::*;

    localparam int WAYS   = 2;
    localparam int SETS   = 128;
    localparam int DATA_W = 64;
    localparam int TAG_W  = 21;
    localparam int PLW    = DATA_W + PAR_W;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    el2_ifu_ic_way_mem_if #(
        .WAYS(WAYS), .SETS(SETS), .DATA_W(DATA_W), .TAG_W(TAG_W)
    ) bus ();

    el2_ifu_ic_way_mem #(
        .WAYS(WAYS), .SETS(SETS), .DATA_W(DATA_W), .TAG_W(TAG_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_req();
        bus.io_rd_en           = 1'b0;
        bus.io_rd_index        = '0;
        bus.io_rd_tag          = '0;
        bus.io_tag_valid       = '0;
        bus.io_wr_en           = '0;
        bus.io_wr_index        = '0;
        bus.io_wr_tag          = '0;
        bus.io_wr_data         = '0;
        bus.io_ecc_disable     = 1'b0;
        bus.io_debug_rd_en     = 1'b0;
        bus.io_debug_wr_en     = 1'b0;
        bus.io_debug_tag_array = 1'b0;
        bus.io_debug_way       = '0;
        bus.io_debug_index     = '0;
        bus.io_debug_wr_data   = '0;
    endtask

    task automatic fill(input logic [1:0] ways, input logic [6:0] idx,
                        input logic [20:0] tag, input logic [63:0] data);
        bus.io_wr_en    = ways;
        bus.io_wr_index = idx;
        bus.io_wr_tag   = tag;
        bus.io_wr_data  = data;
        tick();
        bus.io_wr_en    = '0;
    endtask

    // Issues a lookup; on return the bench sits in the result cycle.
    task automatic lookup(input logic [6:0] idx, input logic [20:0] tag,
                          input logic [1:0] valid, input logic ecc_dis);
        bus.io_rd_en       = 1'b1;
        bus.io_rd_index    = idx;
        bus.io_rd_tag      = tag;
        bus.io_tag_valid   = valid;
        bus.io_ecc_disable = ecc_dis;
        tick();
        bus.io_rd_en       = 1'b0;
        bus.io_ecc_disable = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [1:0] hit,
                                 input logic [63:0] data, input logic [1:0] parerr,
                                 input logic tag_perr, input logic multihit);
        check({tag, "_valid"},    128'(bus.io_rd_valid), 128'(1'b1));
        check({tag, "_hit"},      128'(bus.io_rd_hit),   128'(hit));
        check({tag, "_data"},     128'(bus.io_rd_data),  128'(data));
        check({tag, "_parerr"},   128'(bus.io_parerr),   128'(parerr));
        check({tag, "_tag_perr"}, 128'(bus.io_tag_perr), 128'(tag_perr));
        check({tag, "_multihit"}, 128'(bus.io_multihit), 128'(multihit));
    endtask

    // Raises a debug request, waits (bounded) for done, returns the payload.
    task automatic debug_access(input string tag, input logic wr, input logic tag_arr,
                                input logic [1:0] way, input logic [6:0] idx,
                                input logic [PLW-1:0] payload,
                                output logic [PLW-1:0] rd_data);
        logic seen;
        seen = 1'b0;
        bus.io_debug_rd_en     = ~wr;
        bus.io_debug_wr_en     = wr;
        bus.io_debug_tag_array = tag_arr;
        bus.io_debug_way       = way;
        bus.io_debug_index     = idx;
        bus.io_debug_wr_data   = payload;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            seen = bus.io_debug_done;
        end
        check({tag, "_done_seen"}, 128'(seen), 128'(1'b1));
        rd_data = bus.io_debug_rd_data;
        bus.io_debug_rd_en = 1'b0;
        bus.io_debug_wr_en = 1'b0;
        tick();
    endtask

    initial begin
        logic [PLW-1:0] dbg_rd;

        // Reset state
        clear_req();
        reset = 1'b1;
        tick();
        tick();
        check("rst_valid",   128'(bus.io_rd_valid),      128'(1'b0));
        check("rst_hit",     128'(bus.io_rd_hit),        128'(2'b00));
        check("rst_data",    128'(bus.io_rd_data),       128'(64'h0));
        check("rst_done",    128'(bus.io_debug_done),    128'(1'b0));
        check("rst_dbgdata", 128'(bus.io_debug_rd_data), 128'(68'h0));
        reset = 1'b0;
        tick();

        // Basic fill + hit on way 1
        fill(2'b10, 7'd5, 21'h1ABCD, 64'h0123_4567_89AB_CDEF);
        lookup(7'd5, 21'h1ABCD, 2'b10, 1'b0);
        expect_result("hit_w1", 2'b10, 64'h0123_4567_89AB_CDEF, 2'b00, 1'b0, 1'b0);
        tick();
        check("idle_valid", 128'(bus.io_rd_valid), 128'(1'b0));
        check("idle_data",  128'(bus.io_rd_data),  128'(64'h0));

        // Invalid ways and tag mismatch
        lookup(7'd5, 21'h1ABCD, 2'b00, 1'b0);
        expect_result("no_valid", 2'b00, 64'h0, 2'b00, 1'b0, 1'b0);
        lookup(7'd5, 21'h1ABCE, 2'b10, 1'b0);
        expect_result("tag_miss", 2'b00, 64'h0, 2'b00, 1'b0, 1'b0);

        // Data parity injection on way 0 set 3: correct chunk parity of
        // FEDCBA9876543210 is 4'b0000, chunk 0 bit flipped to 1.
        fill(2'b01, 7'd3, 21'h0AAAA, 64'h0);
        debug_access("dbg_wr_data", 1'b1, 1'b0, 2'd0, 7'd3,
                     68'h1_FEDC_BA98_7654_3210, dbg_rd);
        lookup(7'd3, 21'h0AAAA, 2'b01, 1'b0);
        expect_result("parerr", 2'b01, 64'hFEDC_BA98_7654_3210, 2'b01, 1'b0, 1'b0);
        lookup(7'd3, 21'h0AAAA, 2'b01, 1'b1);
        expect_result("parerr_dis", 2'b01, 64'hFEDC_BA98_7654_3210, 2'b00, 1'b0, 1'b0);

        // Tag parity injection on way 1 set 3: tag 0x0AAAA has even weight,
        // so a stored parity bit of 1 is a mismatch.
        fill(2'b10, 7'd3, 21'h0AAAA, 64'h0);
        debug_access("dbg_wr_tag", 1'b1, 1'b1, 2'd1, 7'd3, 68'h20AAAA, dbg_rd);
        lookup(7'd3, 21'h0AAAA, 2'b10, 1'b0);
        expect_result("tag_perr", 2'b10, 64'h0, 2'b00, 1'b1, 1'b0);

        // Multi-hit
        fill(2'b11, 7'd7, 21'h12345, 64'h1111_2222_3333_4444);
        lookup(7'd7, 21'h12345, 2'b11, 1'b0);
        expect_result("multihit", 2'b11, 64'h1111_2222_3333_4444, 2'b00, 1'b0, 1'b1);

        // Debug read blocked by fetch for 3 cycles
        bus.io_rd_en           = 1'b1;
        bus.io_rd_index        = 7'd7;
        bus.io_rd_tag          = 21'h12345;
        bus.io_tag_valid       = 2'b11;
        bus.io_debug_rd_en     = 1'b1;
        bus.io_debug_tag_array = 1'b0;
        bus.io_debug_way       = 2'd0;
        bus.io_debug_index     = 7'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("blocked_done", 128'(bus.io_debug_done), 128'(1'b0));
        end
        bus.io_rd_en = 1'b0;
        tick();
        check("access_done", 128'(bus.io_debug_done), 128'(1'b0));
        tick();
        check("late_done",   128'(bus.io_debug_done),    128'(1'b1));
        check("late_rddata", 128'(bus.io_debug_rd_data), 128'(68'h1_FEDC_BA98_7654_3210));
        bus.io_debug_rd_en = 1'b0;
        tick();
        check("after_done",  128'(bus.io_debug_done),    128'(1'b0));
        check("held_rddata", 128'(bus.io_debug_rd_data), 128'(68'h1_FEDC_BA98_7654_3210));

        // Debug tag read zero-extends {par, tag}
        debug_access("dbg_rd_tag", 1'b0, 1'b1, 2'd1, 7'd3, 68'h0, dbg_rd);
        check("dbg_rd_tag_data", 128'(dbg_rd), 128'(68'h20AAAA));

        // Out-of-range way reads back zero
        debug_access("dbg_rd_oob", 1'b0, 1'b0, 2'd2, 7'd3, 68'h0, dbg_rd);
        check("dbg_rd_oob_data", 128'(dbg_rd), 128'(68'h0));

        // Same-cycle fill and lookup: read-first
        fill(2'b01, 7'd9, 21'h00009, 64'hAAAA_AAAA_AAAA_AAAA);
        bus.io_wr_en    = 2'b01;
        bus.io_wr_index = 7'd9;
        bus.io_wr_tag   = 21'h00009;
        bus.io_wr_data  = 64'h5555_5555_5555_5555;
        lookup(7'd9, 21'h00009, 2'b01, 1'b0);
        bus.io_wr_en    = '0;
        expect_result("rd_first_old", 2'b01, 64'hAAAA_AAAA_AAAA_AAAA, 2'b00, 1'b0, 1'b0);
        lookup(7'd9, 21'h00009, 2'b01, 1'b0);
        expect_result("rd_first_new", 2'b01, 64'h5555_5555_5555_5555, 2'b00, 1'b0, 1'b0);

        // Reset in the middle of a debug access
        bus.io_debug_wr_en     = 1'b1;
        bus.io_debug_tag_array = 1'b0;
        bus.io_debug_way       = 2'd1;
        bus.io_debug_index     = 7'd20;
        bus.io_debug_wr_data   = 68'h1;
        tick();
        check("mid_access_done", 128'(bus.io_debug_done), 128'(1'b0));
        reset = 1'b1;
        tick();
        check("rst2_done",    128'(bus.io_debug_done),    128'(1'b0));
        check("rst2_valid",   128'(bus.io_rd_valid),      128'(1'b0));
        check("rst2_hit",     128'(bus.io_rd_hit),        128'(2'b00));
        check("rst2_dbgdata", 128'(bus.io_debug_rd_data), 128'(68'h0));
        clear_req();
        reset = 1'b0;
        tick();
        check("post_rst_done1", 128'(bus.io_debug_done), 128'(1'b0));
        tick();
        check("post_rst_done2", 128'(bus.io_debug_done), 128'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/el2_ifu_ic_way_mem.md
Name: el2_ifu_ic_way_mem

Overview:
- Parametrised N-way instruction-cache data+tag array for the IFU, next generation of the stubbed IC memory.
- Holds per-way tag and data with parity, performs a 1-cycle registered lookup with per-way hit, parity checking and hit-way data mux.
- Includes a sequenced debug read/write port for diagnostic access to any way/set.

Parameters:
- WAYS, 2, number of ways (1..4)
- SETS, 128, sets per way (power of 2); IDX_W = log2(SETS)
- DATA_W, 64, fetch data width (multiple of 16); PAR_W = DATA_W/16
- TAG_W, 21, tag width

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- io_rd_en  in  1  lookup request
- io_rd_index  in  IDX_W  lookup set
- io_rd_tag  in  TAG_W  lookup tag
- io_tag_valid  in  WAYS  per-way valid bits for the lookup set, sampled with io_rd_en
- io_wr_en  in  WAYS  one-hot fill-write way select
- io_wr_index  in  IDX_W  fill set
- io_wr_tag  in  TAG_W  fill tag
- io_wr_data  in  DATA_W  fill data
- io_ecc_disable  in  1  suppresses all error outputs
- io_debug_rd_en  in  1  debug read request, held until done
- io_debug_wr_en  in  1  debug write request, held until done
- io_debug_tag_array  in  1  1 = tag array, 0 = data array
- io_debug_way  in  2  way select
- io_debug_index  in  IDX_W  set select
- io_debug_wr_data  in  DATA_W+PAR_W  raw payload incl. parity; tag access uses bits [TAG_W:0]
- io_rd_valid  out  1  lookup result valid
- io_rd_hit  out  WAYS  per-way hit
- io_rd_data  out  DATA_W  OR-mux of hit-way data
- io_parerr  out  WAYS  data parity error on hit way
- io_tag_perr  out  1  tag parity error on any valid way
- io_multihit  out  1  more than one way hit
- io_debug_done  out  1  one-cycle completion pulse
- io_debug_rd_data  out  DATA_W+PAR_W  raw debug read payload, zero-extended for tag reads

Behaviour:
- Reset: all outputs 0; debug FSM to IDLE; lookup pipeline register cleared. Arrays are not reset.
- Parity: even parity.
  - Fill: 1 parity bit per 16-bit data chunk, plus 1 bit over the tag, generated on write.
  - Debug write: stores payload parity bits verbatim, enabling error injection.
- Lookup, latency 1:
  - io_rd_en in cycle N produces io_rd_valid=1 in cycle N+1 with results; io_rd_valid=0 otherwise, and all result outputs 0 when not valid.
  - hit[w] = valid[w] & (stored_tag[w] == rd_tag).
  - io_rd_data = OR over w of (hit[w] ? data[w] : 0).
  - io_multihit = popcount(hit) > 1.
  - io_parerr[w] = hit[w] & data parity mismatch.
  - io_tag_perr = OR over valid ways of tag parity mismatch.
  - All error outputs are forced 0 when io_ecc_disable is high in cycle N.
- Same-cycle fill write and lookup to the same set: read-first; the lookup returns pre-write contents.
- Multiple bits in io_wr_en: every selected way is written. Allowed, not checked.
- Debug FSM IDLE -> ACCESS -> DONE -> IDLE:
  - IDLE -> ACCESS when a debug request is present and io_rd_en=0 and io_wr_en=0; otherwise stay IDLE (fetch has priority).
  - ACCESS: perform the array access. Write wins if rd_en and wr_en are both high. Debug write also overrides a same-cycle fill to the same location.
  - DONE: pulse io_debug_done; io_debug_rd_data is valid and held until the next debug read completes.
  - Requester must drop the request in the cycle after done. A request still high in IDLE starts a new access.
- io_debug_way >= WAYS: write ignored, read returns 0, done still pulses.
- Reset during ACCESS/DONE: return to IDLE, no done pulse, array content at that location undefined.

Decomposition:
- Shared package el2_ifu_ic_pkg: parity-generate function, debug FSM state enum, derived widths IDX_W and PAR_W.
- One sub-module el2_ifu_ic_way_bank: single-way tag+data storage with read port, write port and parity check outputs, instantiated WAYS times.
- The top holds hit mux, error gating and debug FSM.

Test Plan:
- Fill way1 set 5 tag 0x1ABCD data 0x0123456789ABCDEF, then lookup set 5 tag 0x1ABCD valid=2'b10 -> next cycle rd_valid=1, hit=2'b10, rd_data=0x0123456789ABCDEF, no errors.
- Same lookup with valid=2'b00 -> hit=0, rd_data=0. Lookup tag 0x1ABCE -> hit=0.
- Debug write data way0 set 3 with one chunk parity bit flipped; fill tag; lookup hit -> parerr=2'b01. Repeat with io_ecc_disable=1 -> parerr=0.
- Fill both ways set 7 with identical tag; lookup valid=2'b11 -> multihit=1, hit=2'b11.
- Debug read held while io_rd_en=1 for 3 cycles -> no done during those cycles. Done pulses 2 cycles after rd_en drops, with the payload equal to the written raw data incl. parity.
- Same-cycle fill and lookup to set 9 -> old data returned. Lookup one cycle later -> new data. Assert reset mid-ACCESS -> no done, FSM IDLE, all outputs 0.
